// File: rtl/stack_game_ctrl.sv
// Block-stacking game sequencer: play FSM, level-paced shift strobe, alignment judge.
// Define STACK_AUTOSPEED_EN to shrink the shift period per cleared level.
module stack_game_ctrl #(
  parameter int unsigned START_PERIOD = 200,
  parameter int unsigned PERIOD_STEP  = 20,
  parameter int unsigned MIN_PERIOD   = 40,
  parameter int unsigned NUM_LEVELS   = 8
) (
  input  logic       clk,
  input  logic       rstBtn,
  input  logic       tick,
  input  logic       stopPulse,
  input  logic [7:0] blockLoc,
  output logic       loadBlock,
  output logic [7:0] newBlock,
  output logic       shiftPulse,
  output logic [7:0] stackRow,
  output logic [3:0] level,
  output logic [7:0] period,
  output logic       winLED,
  output logic       loseLED
);

  // state | meaning
  // IDLE  | waiting for the first stop press
  // LOAD  | one cycle, shifter takes stackRow as the new block
  // RUN   | block moving, shift strobe every period ticks
  // CHECK | one cycle, judge captured block against stackRow
  // WIN   | all levels cleared, winLED on
  // LOSE  | no overlap, loseLED on
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_CHECK, S_WIN, S_LOSE} state_t;

  localparam logic [7:0] START_P = 8'(START_PERIOD);
  localparam logic [3:0] NUM_L   = 4'(NUM_LEVELS);

  if (START_PERIOD < 1 || START_PERIOD > 255 || MIN_PERIOD < 1 || MIN_PERIOD > 255 ||
      PERIOD_STEP > 255 || NUM_LEVELS < 1 || NUM_LEVELS > 15) begin : g_bad_params
    $error("stack_game_ctrl: parameter out of range");
  end

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] cap_q, cap_d;
  logic [7:0] row_q, row_d;
  logic [3:0] level_q, level_d;
  logic [7:0] period_q, period_d;
  logic       load_q, load_d;
  logic       shift_q, shift_d;
  logic       win_q, win_d;
  logic       lose_q, lose_d;
  logic [7:0] overlap;

`ifdef STACK_AUTOSPEED_EN
  localparam logic [7:0] STEP_P = 8'(PERIOD_STEP);
  localparam logic [7:0] MIN_P  = 8'(MIN_PERIOD);
  logic [8:0] period_diff;
  logic [7:0] next_period;

  // Borrow out of the 9-bit difference flags the 8-bit underflow.
  always_comb begin
    period_diff = {1'b0, period_q} - {1'b0, STEP_P};
    next_period = period_diff[7:0];
    if (period_diff[8] || (period_diff[7:0] < MIN_P)) next_period = MIN_P;
  end
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cap_d    = cap_q;
    row_d    = row_q;
    level_d  = level_q;
    period_d = period_q;
    shift_d  = 1'b0;
    overlap  = cap_q & row_q;

    case (state_q)
      S_IDLE: begin
        if (stopPulse) state_d = S_LOAD;
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        // A stop in the same cycle as a tick swallows the tick.
        if (stopPulse) begin
          cap_d   = blockLoc;
          state_d = S_CHECK;
        end else if (tick) begin
          if (cnt_q == period_q - 8'd1) begin
            shift_d = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_CHECK: begin
        if (overlap == 8'h00) begin
          state_d = S_LOSE;
        end else begin
          row_d   = overlap;
          level_d = level_q + 4'd1;
          if (level_q + 4'd1 == NUM_L) begin
            state_d = S_WIN;
          end else begin
`ifdef STACK_AUTOSPEED_EN
            period_d = next_period;
`endif
            state_d = S_LOAD;
          end
        end
      end
      S_WIN, S_LOSE: begin
        if (stopPulse) begin
          state_d  = S_IDLE;
          cnt_d    = '0;
          cap_d    = '0;
          row_d    = 8'hFF;
          level_d  = '0;
          period_d = START_P;
        end
      end
      default: state_d = S_IDLE;
    endcase

    load_d = (state_d == S_LOAD);
    win_d  = (state_d == S_WIN);
    lose_d = (state_d == S_LOSE);
  end

  always_ff @(posedge clk) begin
    if (rstBtn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      cap_q    <= '0;
      row_q    <= 8'hFF;
      level_q  <= '0;
      period_q <= START_P;
      load_q   <= 1'b0;
      shift_q  <= 1'b0;
      win_q    <= 1'b0;
      lose_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cap_q    <= cap_d;
      row_q    <= row_d;
      level_q  <= level_d;
      period_q <= period_d;
      load_q   <= load_d;
      shift_q  <= shift_d;
      win_q    <= win_d;
      lose_q   <= lose_d;
    end
  end

  assign loadBlock  = load_q;
  assign newBlock   = row_q;
  assign shiftPulse = shift_q;
  assign stackRow   = row_q;
  assign level      = level_q;
  assign period     = period_q;
  assign winLED     = win_q;
  assign loseLED    = lose_q;

endmodule

// File: tb/tb_stack_game_ctrl.sv
// Bench for stack_game_ctrl: directed game scenarios plus random soak against a
// game-level reference model (phases, tick tally, overlap arithmetic).
module tb_stack_game_ctrl;

  localparam int START_PERIOD = 200;
  localparam int PERIOD_STEP  = 20;
  localparam int MIN_PERIOD   = 40;
  localparam int NUM_LEVELS   = 8;

  logic       clk = 1'b0;
  logic       rstBtn = 1'b0, tick = 1'b0, stopPulse = 1'b0;
  logic [7:0] blockLoc = 8'h00;
  logic       loadBlock, shiftPulse, winLED, loseLED;
  logic [7:0] newBlock, stackRow, period;
  logic [3:0] level;

  stack_game_ctrl #(
    .START_PERIOD(START_PERIOD), .PERIOD_STEP(PERIOD_STEP),
    .MIN_PERIOD(MIN_PERIOD), .NUM_LEVELS(NUM_LEVELS)
  ) dut (
    .clk(clk), .rstBtn(rstBtn), .tick(tick), .stopPulse(stopPulse), .blockLoc(blockLoc),
    .loadBlock(loadBlock), .newBlock(newBlock), .shiftPulse(shiftPulse),
    .stackRow(stackRow), .level(level), .period(period), .winLED(winLED), .loseLED(loseLED)
  );

  always #5 clk = ~clk;

  // game phases of the reference model
  localparam int PH_IDLE = 0, PH_LOADING = 1, PH_MOVING = 2, PH_JUDGING = 3, PH_WON = 4, PH_LOST = 5;

  int m_ph, m_row, m_level, m_period, m_ticks, m_cap;
  bit e_shift;
  int vectors = 0;
  int miscompares = 0;

  task automatic model_reset();
    m_ph = PH_IDLE; m_row = 255; m_level = 0; m_period = START_PERIOD;
    m_ticks = 0; m_cap = 0;
  endtask

  task automatic model_edge(input bit r, input bit t, input bit s, input int loc);
    int ov;
    e_shift = 1'b0;
    if (r) begin
      model_reset();
    end else begin
      case (m_ph)
        PH_IDLE:    if (s) m_ph = PH_LOADING;
        PH_LOADING: begin m_ticks = 0; m_ph = PH_MOVING; end
        PH_MOVING: begin
          if (s) begin
            m_cap = loc; m_ph = PH_JUDGING;
          end else if (t) begin
            m_ticks++;
            if (m_ticks % m_period == 0) e_shift = 1'b1;
          end
        end
        PH_JUDGING: begin
          ov = m_cap & m_row;
          if (ov == 0) m_ph = PH_LOST;
          else begin
            m_row = ov;
            m_level++;
            if (m_level == NUM_LEVELS) m_ph = PH_WON;
            else begin
`ifdef STACK_AUTOSPEED_EN
              m_period = (m_period - PERIOD_STEP < MIN_PERIOD) ? MIN_PERIOD : m_period - PERIOD_STEP;
`endif
              m_ph = PH_LOADING;
            end
          end
        end
        default: if (s) model_reset();
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("loadBlock",  {7'b0, loadBlock},  8'(m_ph == PH_LOADING));
    chk("shiftPulse", {7'b0, shiftPulse}, 8'(e_shift));
    chk("stackRow",   stackRow,           8'(m_row));
    chk("newBlock",   newBlock,           8'(m_row));
    chk("level",      {4'b0, level},      8'(m_level));
    chk("period",     period,             8'(m_period));
    chk("winLED",     {7'b0, winLED},     8'(m_ph == PH_WON));
    chk("loseLED",    {7'b0, loseLED},    8'(m_ph == PH_LOST));
  endtask

  // drive on the falling edge, model the rising edge, compare on the next falling edge
  task automatic step(input bit r, input bit t, input bit s, input logic [7:0] loc);
    rstBtn = r; tick = t; stopPulse = s; blockLoc = loc;
    @(posedge clk);
    model_edge(r, t, s, int'(loc));
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int shifts;
    model_reset();
    e_shift = 1'b0;
    @(negedge clk);

    // reset, then idle with ticks
    step(1, 0, 0, 8'h00);
    chk("reset_row", stackRow, 8'hFF);
    chk("reset_period", period, 8'(START_PERIOD));
    for (int i = 0; i < 1000; i++) step(0, 1, 0, 8'($urandom));

    // start, stop during LOAD ignored, cadence over 450 consecutive ticks
    step(0, 0, 1, 8'h00);
    step(0, 1, 1, 8'h00);
    shifts = 0;
    for (int i = 0; i < 450; i++) begin
      step(0, 1, 0, 8'($urandom));
      if (shiftPulse) shifts++;
    end
    chk("shift_count", 8'(shifts), 8'd2);

    // partial overlap, stop+tick during CHECK ignored, load two cycles after stop
    step(0, 0, 1, 8'h3C);
    step(0, 1, 1, 8'h00);
    chk("load_after_pass", {7'b0, loadBlock}, 8'd1);
    chk("newblock_after_pass", newBlock, 8'h3C);
    for (int i = 0; i < 20; i++) step(0, 1'($urandom), 0, 8'($urandom));

    // miss, linger in LOSE, then stop back to IDLE
    step(0, 0, 1, 8'hC0);
    step(0, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 8'h00);
    chk("lose_led", {7'b0, loseLED}, 8'd1);
    step(0, 0, 1, 8'h00);
    step(0, 0, 0, 8'h00);

    // perfect game to WIN
    step(0, 0, 1, 8'h00);
    for (int lvl = 0; lvl < NUM_LEVELS; lvl++) begin
      int n;
      n = $urandom_range(1, 30);
      for (int i = 0; i < n; i++) step(0, 1'($urandom), 0, 8'($urandom));
      step(0, 0, 1, 8'hFF);
      step(0, 0, 0, 8'h00);
    end
    for (int i = 0; i < 4; i++) step(0, 1, 0, 8'h00);
    chk("win_led", {7'b0, winLED}, 8'd1);
    step(0, 0, 1, 8'h00);

    // stop and tick together on the terminal tick
    step(0, 0, 1, 8'h00);
    step(0, 0, 0, 8'h00);
    for (int i = 0; i < 300 && (m_ticks % m_period) != m_period - 1; i++)
      step(0, 1, 0, 8'h00);
    step(0, 1, 1, 8'hFF);
    step(0, 0, 0, 8'h00);
    chk("simul_no_shift", {7'b0, shiftPulse}, 8'd0);

    // reset mid-RUN wins over stop and tick
    for (int i = 0; i < 5; i++) step(0, 1, 0, 8'h00);
    step(1, 1, 1, 8'h00);
    chk("rst_level", {4'b0, level}, 8'd0);

    // random soak
    for (int i = 0; i < 4000; i++) begin
      logic [7:0] loc;
      loc = ($urandom_range(0, 2) != 0) ? 8'(m_row | 8'($urandom)) : 8'($urandom);
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 1) == 0),
           ($urandom_range(0, 19) == 0), loc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
